// File: rtl/pattern_frame_tx.sv
// pattern_frame_tx: serial frame transmitter (sync pattern + payload word + idle gap)
//
// Sends PAT (MSB first), then the DATA_W-bit payload (MSB first), one bit per
// en_i strobe, then waits GAP strobes before it can accept another frame.
//
// Ports:
//   clk_i    rising-edge clock
//   rst_i    asynchronous reset, active-low
//   en_i     bit-rate strobe; one bit advances per sampled en_i=1
//   start_i  frame request, accepted only while ready_o=1
//   data_i   payload word, captured on acceptance
//   ready_o  idle, able to accept start_i
//   d_o      registered serial bit
//   valid_o  registered, d_o carries a frame bit this cycle
//   done_o   registered pulse coincident with the last payload bit
module pattern_frame_tx #(
    parameter int                PAT_W  = 5,
    parameter logic [PAT_W-1:0]  PAT    = 5'b11011,
    parameter int                DATA_W = 8,
    parameter int                GAP    = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              start_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              ready_o,
    output logic              d_o,
    output logic              valid_o,
    output logic              done_o
);
    localparam int M1 = (PAT_W > DATA_W) ? PAT_W : DATA_W;
    localparam int M2 = (M1 > GAP) ? M1 : GAP;
    localparam int M3 = (M2 > 2) ? M2 : 2;
    localparam int CW = $clog2(M3);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SYNC = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     idx_q, idx_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic              d_q, d_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;
    logic [PAT_W-1:0]  pat_sh;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        // d_o holds its last bit while a frame is in flight, reads 0 when idle
        d_d     = (state_q == S_IDLE || state_q == S_GAP) ? 1'b0 : d_q;
        valid_d = 1'b0;
        done_d  = 1'b0;
        pat_sh  = PAT << idx_q;
        case (state_q)
            S_IDLE: if (start_i) begin
                sh_d    = data_i;
                idx_d   = '0;
                state_d = S_SYNC;
            end
            S_SYNC: if (en_i) begin
                d_d     = pat_sh[PAT_W-1];
                valid_d = 1'b1;
                idx_d   = (idx_q == CW'(PAT_W - 1)) ? '0 : idx_q + CW'(1);
                state_d = (idx_q == CW'(PAT_W - 1)) ? S_DATA : S_SYNC;
            end
            S_DATA: if (en_i) begin
                d_d     = sh_q[DATA_W-1];
                valid_d = 1'b1;
                sh_d    = sh_q << 1;
                done_d  = (idx_q == CW'(DATA_W - 1));
                idx_d   = done_d ? '0 : idx_q + CW'(1);
                state_d = !done_d ? S_DATA : (GAP > 0) ? S_GAP : S_IDLE;
            end
            default: if (en_i) begin
                idx_d   = (idx_q == CW'(GAP - 1)) ? '0 : idx_q + CW'(1);
                state_d = (idx_q == CW'(GAP - 1)) ? S_IDLE : S_GAP;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            sh_q    <= '0;
            d_q     <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            d_q     <= d_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign ready_o = (state_q == S_IDLE);
    assign d_o     = d_q;
    assign valid_o = valid_q;
    assign done_o  = done_q;
endmodule

// File: tb/tb_pattern_frame_tx.sv
// tb_pattern_frame_tx: table-driven and directed checks of pattern_frame_tx
module tb_pattern_frame_tx;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, start, start_g, start_s;
    logic [7:0] data, data_g;
    logic [3:0] data_s;
    logic       ready, d, valid, done;
    logic       ready_g, d_g, valid_g, done_g;
    logic       ready_s, d_s, valid_s, done_s;

    always #5 clk = ~clk;

    pattern_frame_tx dut (
        .clk_i(clk), .rst_i(rst_n), .en_i(en), .start_i(start), .data_i(data),
        .ready_o(ready), .d_o(d), .valid_o(valid), .done_o(done)
    );

    pattern_frame_tx #(.GAP(0)) dut_g0 (
        .clk_i(clk), .rst_i(rst_n), .en_i(en), .start_i(start_g), .data_i(data_g),
        .ready_o(ready_g), .d_o(d_g), .valid_o(valid_g), .done_o(done_g)
    );

    pattern_frame_tx #(.PAT_W(3), .PAT(3'b101), .DATA_W(4)) dut_s (
        .clk_i(clk), .rst_i(rst_n), .en_i(en), .start_i(start_s), .data_i(data_s),
        .ready_o(ready_s), .d_o(d_s), .valid_o(valid_s), .done_o(done_s)
    );

    typedef struct {
        logic       en;
        logic       start;
        logic [7:0] data;
        logic       v;
        logic       d;
        logic       dn;
        logic       rdy;
    } row_t;

    row_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void add(input logic e, input logic s, input logic [7:0] dat,
                                input logic v, input logic dd, input logic dn, input logic r);
        row_t x;
        x.en = e; x.start = s; x.data = dat; x.v = v; x.d = dd; x.dn = dn; x.rdy = r;
        tbl.push_back(x);
    endfunction

    // One frame of rows: accept, 13 bits with en every per cycles, 2 gap strobes, one idle row.
    // noise drives start_i=1 with data 8'hFF throughout the busy period.
    function automatic void add_frame(input logic [7:0] dat, input logic [12:0] bits,
                                      input int per, input logic noise);
        logic held = 1'b0;
        logic e;
        int   j = 0;
        add(per == 1, 1'b1, dat, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 13 * per; k++) begin
            e = (k % per == 0);
            if (e) begin
                j = k / per - 1;
                held = bits[12-j];
            end
            add(e, noise, noise ? 8'hFF : 8'h00, e, held, e && (j == 12), 1'b0);
        end
        for (int k = 13 * per + 1; k <= 15 * per; k++)
            add(k % per == 0, noise, noise ? 8'hFF : 8'h00, 1'b0, 1'b0, 1'b0, k == 15 * per);
        add(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    endfunction

    task automatic run_table(input string name);
        foreach (tbl[i]) begin
            en = tbl[i].en; start = tbl[i].start; data = tbl[i].data;
            @(posedge clk); #1;
            checks++;
            if ({valid, d, done, ready} !== {tbl[i].v, tbl[i].d, tbl[i].dn, tbl[i].rdy}) begin
                errors++;
                $display("FAIL %s row %0d: got valid=%b d=%b done=%b ready=%b, want valid=%b d=%b done=%b ready=%b",
                         name, i, valid, d, done, ready, tbl[i].v, tbl[i].d, tbl[i].dn, tbl[i].rdy);
            end
        end
        tbl.delete();
        start = 1'b0;
    endtask

    task automatic chk(input string name, input logic [3:0] got, input logic [3:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got {valid,d,done,ready}=%b, want %b", name, got, want);
        end
    endtask

    initial begin
        logic [4:0] p5 = 5'b11011;
        logic [6:0] sbits = 7'b1011001;
        int m;
        int ndone = 0;
        en = 1'b1; start = 1'b0; data = '0;
        start_g = 1'b0; data_g = '0; start_s = 1'b0; data_s = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        chk("reset_state", {valid, d, done, ready}, 4'b0001);
        rst_n = 1'b1;
        @(posedge clk); #1;

        add_frame(8'hA5, 13'b11011_10100101, 1, 1'b0);
        run_table("frame_a5");
        add_frame(8'h3C, 13'b11011_00111100, 3, 1'b0);
        run_table("en_div3");
        add_frame(8'h5A, 13'b11011_01011010, 1, 1'b1);
        add_frame(8'hFF, 13'b11011_11111111, 1, 1'b0);
        run_table("busy_ignore");

        en = 1'b1; start = 1'b1; data = 8'hA5;
        @(posedge clk); #1;
        start = 1'b0; data = 8'h00;
        repeat (7) begin
            @(posedge clk); #1;
        end
        chk("bit7_before_reset", {valid, d, done, ready}, 4'b1000);
        #3 rst_n = 1'b0;
        #1 chk("async_reset", {valid, d, done, ready}, 4'b0001);
        @(posedge clk); #1;
        chk("reset_held", {valid, d, done, ready}, 4'b0001);
        rst_n = 1'b1;
        add_frame(8'hA5, 13'b11011_10100101, 1, 1'b0);
        run_table("after_reset");

        en = 1'b1; start_g = 1'b1; data_g = 8'h00;
        for (int c = 0; c < 42; c++) begin
            @(posedge clk); #1;
            m = c % 14;
            ndone += int'(done_g);
            chk($sformatf("gap0_c%0d", c), {valid_g, d_g, done_g, ready_g},
                {m != 0, (m >= 1 && m <= 5) ? p5[5-m] : 1'b0, m == 13, m == 13});
        end
        start_g = 1'b0;
        checks++;
        if (ndone != 3) begin
            errors++;
            $display("FAIL gap0_done_count: got %0d, want 3", ndone);
        end

        start_s = 1'b1; data_s = 4'h9;
        @(posedge clk); #1;
        start_s = 1'b0;
        chk("small_accept", {valid_s, d_s, done_s, ready_s}, 4'b0000);
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            chk($sformatf("small_c%0d", c), {valid_s, d_s, done_s, ready_s},
                {c <= 7, (c <= 7) ? sbits[7-c] : 1'b0, c == 7, 1'b0});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
